// File: rtl/o_serdes_tri_pkg.sv
// Shared types and limits for the o_serdes_tri parallel-to-serial output stage.
package o_serdes_tri_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 10;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/o_serdes_tri_if.sv
// Word handshake and serial/tristate outputs of o_serdes_tri.
interface o_serdes_tri_if #(parameter int WIDTH = 4);

    logic [WIDTH-1:0] D;
    logic             OE_IN;
    logic             D_VALID;
    logic             D_READY;
    logic             Q;
    logic             T_OUT;
    logic             BUSY;
    logic             WORD_DONE;

    modport master (
        output D, OE_IN, D_VALID,
        input  D_READY, Q, T_OUT, BUSY, WORD_DONE
    );

    modport slave (
        input  D, OE_IN, D_VALID,
        output D_READY, Q, T_OUT, BUSY, WORD_DONE
    );

endinterface

// File: rtl/o_serdes_tri_shreg.sv
// Loadable right-shift register; sout is the next bit to be presented.
module o_serdes_tri_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else if (load)
            sr <= din;
        else if (shift)
            sr <= {1'b0, sr[WIDTH-1:1]};
    end

    assign sout = sr[0];

endmodule

// File: rtl/o_serdes_tri.sv
// Parallel-to-serial output stage, LSB first, with per-word tristate control
// and a one-word holding register for gapless back-to-back transfers.
module o_serdes_tri
    import o_serdes_tri_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    o_serdes_tri_if.slave    bus
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "o_serdes_tri: WIDTH must be in 3..10");
    end

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hold;
    logic             hold_oe, hold_full;
    logic             q_r, t_r, busy_r, wd_r;
    logic             q_n, t_n, busy_n, wd_n;
    logic             load, shift, reload, sout, accept;

    assign accept = bus.D_VALID && !hold_full;

    // Only bits 1.. go into the shifter; bit 0 goes straight to Q on load.
    o_serdes_tri_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (CLK),
        .rst   (RST),
        .load  (load),
        .shift (shift),
        .din   ({1'b0, hold[WIDTH-1:1]}),
        .sout  (sout)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = 1'b0;
        t_n     = 1'b0;
        busy_n  = 1'b0;
        wd_n    = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        reload  = 1'b0;
        case (state)
            IDLE: reload = hold_full;
            SHIFT: begin
                if (cnt == CNT_LAST) begin
                    if (hold_full)
                        reload = 1'b1;
                    else
                        state_n = IDLE;
                end else begin
                    shift  = 1'b1;
                    q_n    = sout;
                    t_n    = t_r;
                    busy_n = 1'b1;
                    cnt_n  = cnt + CW'(1);
                    wd_n   = (cnt == CNT_PRE);
                end
            end
            default: state_n = IDLE;
        endcase
        if (reload) begin
            load    = 1'b1;
            state_n = SHIFT;
            q_n     = hold[0];
            t_n     = hold_oe;
            busy_n  = 1'b1;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            q_r       <= 1'b0;
            t_r       <= 1'b0;
            busy_r    <= 1'b0;
            wd_r      <= 1'b0;
            hold_full <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            q_r    <= q_n;
            t_r    <= t_n;
            busy_r <= busy_n;
            wd_r   <= wd_n;
            // accept needs an empty holder and load a full one, so never both
            if (accept) begin
                hold      <= bus.D;
                hold_oe   <= bus.OE_IN;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign bus.D_READY   = !hold_full;
    assign bus.Q         = q_r;
    assign bus.T_OUT     = t_r;
    assign bus.BUSY      = busy_r;
    assign bus.WORD_DONE = wd_r;

endmodule

// File: tb/tb_o_serdes_tri.sv
// Bench for o_serdes_tri: scoreboard of per-bit expectations plus timed sequences.
module tb_o_serdes_tri;

    localparam int W = 4;

    logic CLK = 1'b0;
    logic RST;

    o_serdes_tri_if #(.WIDTH(W)) bus();

    o_serdes_tri #(.WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic q; logic t; logic last; } exp_t;
    typedef struct packed { logic q; logic t; logic wd; logic busy; } obs_t;
    typedef struct { logic [W-1:0] d; logic oe; logic [W-1:0] seq; logic t; } vec_t;

    exp_t sbq[$];
    obs_t log_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected bits are queued at the accepting edge, LSB first.
    always @(posedge CLK) begin
        if (RST)
            sbq.delete();
        else if (bus.D_VALID && bus.D_READY)
            for (int k = 0; k < W; k++)
                sbq.push_back('{q: bus.D[k], t: bus.OE_IN, last: (k == W - 1)});
    end

    always @(negedge CLK) begin
        exp_t e;
        log_q.push_back('{q: bus.Q, t: bus.T_OUT, wd: bus.WORD_DONE, busy: bus.BUSY});
        if (!RST) begin
            if (bus.BUSY) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: BUSY=1 with no expected bit queued");
                end else begin
                    e = sbq.pop_front();
                    chk("sb_q", 32'(bus.Q), 32'(e.q));
                    chk("sb_t", 32'(bus.T_OUT), 32'(e.t));
                    chk("sb_wd", 32'(bus.WORD_DONE), 32'(e.last));
                end
            end else begin
                chk("sb_idle", 32'({bus.Q, bus.T_OUT, bus.WORD_DONE}), 32'd0);
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic oe);
        bit acc;
        bus.D       = d;
        bus.OE_IN   = oe;
        bus.D_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = bus.D_READY;
            tick();
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: word %0h not accepted within 20 cycles", d);
    endtask

    function automatic int first_busy();
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].busy) return i;
        return -1;
    endfunction

    initial begin
        int fb;
        int nbusy;
        logic [11:0] b2b_q;
        logic [7:0]  tri_q;
        logic [7:0]  tri_t;

        // time-ordered expected serial patterns (first bit is the MSB here)
        vecs[0] = '{d: 4'b1011, oe: 1'b1, seq: 4'b1101, t: 1'b1};
        vecs[1] = '{d: 4'b0000, oe: 1'b1, seq: 4'b0000, t: 1'b1};
        vecs[2] = '{d: 4'b1111, oe: 1'b0, seq: 4'b1111, t: 1'b0};
        vecs[3] = '{d: 4'b0001, oe: 1'b1, seq: 4'b1000, t: 1'b1};
        vecs[4] = '{d: 4'b0110, oe: 1'b0, seq: 4'b0110, t: 1'b0};
        b2b_q = 12'b010110101111;
        tri_q = 8'b00111100;
        tri_t = 8'b11110000;

        RST         = 1'b1;
        bus.D       = 4'hF;
        bus.OE_IN   = 1'b1;
        bus.D_VALID = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_q", 32'(bus.Q), 32'd0);
            chk("rst_t", 32'(bus.T_OUT), 32'd0);
            chk("rst_busy", 32'(bus.BUSY), 32'd0);
            chk("rst_ready", 32'(bus.D_READY), 32'd1);
            chk("rst_wd", 32'(bus.WORD_DONE), 32'd0);
        end
        RST         = 1'b0;
        bus.D_VALID = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", 32'(bus.BUSY), 32'd0);
        chk("post_rst_ready", 32'(bus.D_READY), 32'd1);

        foreach (vecs[v]) begin
            send(vecs[v].d, vecs[v].oe);
            bus.D_VALID = 1'b0;
            for (int k = 0; k < W; k++) begin
                tick();
                chk("vec_q", 32'(bus.Q), 32'(vecs[v].seq[W-1-k]));
                chk("vec_t", 32'(bus.T_OUT), 32'(vecs[v].t));
                chk("vec_wd", 32'(bus.WORD_DONE), 32'(k == W - 1));
                chk("vec_busy", 32'(bus.BUSY), 32'd1);
            end
            tick();
            chk("vec_end", 32'({bus.Q, bus.T_OUT, bus.BUSY, bus.WORD_DONE}), 32'd0);
            tick();
        end

        log_q.delete();
        send(4'hA, 1'b1);
        send(4'h5, 1'b1);
        send(4'hF, 1'b1);
        bus.D_VALID = 1'b0;
        repeat (14) tick();
        fb = first_busy();
        chk("b2b_latency", 32'(fb), 32'd2);
        if (fb >= 0 && log_q.size() > fb + 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("b2b_q", 32'(log_q[fb+i].q), 32'(b2b_q[11-i]));
                chk("b2b_t", 32'(log_q[fb+i].t), 32'd1);
                chk("b2b_busy", 32'(log_q[fb+i].busy), 32'd1);
                chk("b2b_wd", 32'(log_q[fb+i].wd), 32'((i % 4) == 3));
            end
            chk("b2b_end", 32'(log_q[fb+12].busy), 32'd0);
        end

        log_q.delete();
        send(4'hC, 1'b1);
        send(4'h3, 1'b0);
        bus.D_VALID = 1'b0;
        repeat (12) tick();
        fb = first_busy();
        chk("tri_latency", 32'(fb), 32'd2);
        if (fb >= 0 && log_q.size() > fb + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("tri_q", 32'(log_q[fb+i].q), 32'(tri_q[7-i]));
                chk("tri_t", 32'(log_q[fb+i].t), 32'(tri_t[7-i]));
            end
            chk("tri_end", 32'({log_q[fb+8].busy, log_q[fb+8].t}), 32'd0);
        end

        // abort 4'h6 after its second bit while 4'h9 sits in the holder
        send(4'h6, 1'b1);
        send(4'h9, 1'b1);
        bus.D_VALID = 1'b0;
        chk("abort_pre_q", 32'(bus.Q), 32'd1);
        chk("abort_pre_ready", 32'(bus.D_READY), 32'd0);
        RST = 1'b1;
        tick();
        chk("abort_q", 32'(bus.Q), 32'd0);
        chk("abort_t", 32'(bus.T_OUT), 32'd0);
        chk("abort_ready", 32'(bus.D_READY), 32'd1);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        RST = 1'b0;
        log_q.delete();
        repeat (10) tick();
        nbusy = 0;
        foreach (log_q[i]) if (log_q[i].busy || log_q[i].t) nbusy++;
        chk("abort_held_dropped", 32'(nbusy), 32'd0);

        repeat (40) begin
            bus.D       = W'($urandom);
            bus.OE_IN   = 1'($urandom);
            bus.D_VALID = 1'b1;
            tick();
        end
        bus.D_VALID = 1'b0;
        repeat (3 * W + 2) tick();
        chk("bp_drain", 32'(sbq.size()), 32'd0);
        chk("bp_idle", 32'({bus.BUSY, bus.D_READY}), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
